// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_PRE,
        ST_ST1,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_SKIP
    } mdio_state_e;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;
    localparam logic [4:0] REG_ANAR = 5'd4;

    localparam logic [15:0] BMCR_RST   = 16'h3100;
    localparam logic [15:0] ANAR_RST   = 16'h01E1;
    localparam logic [15:0] BMSR_FIXED = 16'h7809;

    function automatic logic [15:0] reg_rst_val(input logic [4:0] idx);
        case (idx)
            REG_BMCR: return BMCR_RST;
            REG_ANAR: return ANAR_RST;
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic logic reg_is_ro(input logic [4:0] idx);
        return (idx == REG_BMSR) || (idx == REG_ID1) || (idx == REG_ID2);
    endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer with a rising-edge strobe on the synchronized signal.
module mdio_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            dly_q  <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~dly_q;

endmodule

// File: rtl/eth_mdio_responder.sv
// PHY-side Clause-22 MDIO responder serving a 32 x 16 register file.
// state | meaning: PRE count ones | ST1 expect ST low-order 1 | HDR op/phy/reg | TA turnaround | DATA 16 bits | SKIP ignore frame
module eth_mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHYID1   = 16'h0007,
    parameter logic [15:0] PHYID2   = 16'hC0F1,
    parameter int          PRE_MIN  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        link_up,
    input  logic        an_done,
    output logic        wr_valid,
    output logic [4:0]  wr_regad,
    output logic [15:0] wr_data
);

    localparam int PCW = $clog2(PRE_MIN + 1);
    localparam logic [PCW-1:0] PRE_MIN_C = PCW'(PRE_MIN);

    logic mdc_rise, mdc_s_unused, mdio_s, mdio_rise_unused;

    mdio_sync_edge #(.RST_VAL(1'b0)) u_mdc_sync (
        .clk(clk), .rst(rst), .d_i(mdc), .q_o(mdc_s_unused), .rise_o(mdc_rise)
    );
    mdio_sync_edge #(.RST_VAL(1'b1)) u_mdio_sync (
        .clk(clk), .rst(rst), .d_i(mdio_i), .q_o(mdio_s), .rise_o(mdio_rise_unused)
    );

    mdio_state_e    state_q, state_d;
    logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [10:0]    hdr_q, hdr_d;
    logic [4:0]     regad_q, regad_d;
    logic           rd_q, rd_d;
    logic [15:0]    sr_q, sr_d;
    logic           mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
    logic           wr_valid_q, wr_valid_d;
    logic [4:0]     wr_regad_q, wr_regad_d;
    logic [15:0]    wr_data_q, wr_data_d;
    logic [15:0]    regs_q [32];

    logic [4:0]  rd_addr;
    logic [15:0] rd_word, wr_word, wr_store;
    logic        hdr_ok, wr_en;

    assign rd_addr  = {hdr_q[3:0], mdio_s};
    assign hdr_ok   = ((hdr_q[10:9] == OP_READ) || (hdr_q[10:9] == OP_WRITE)) && (hdr_q[8:4] == PHY_ADDR);
    assign wr_word  = {sr_q[14:0], mdio_s};
    assign wr_store = (regad_q == REG_BMCR) ? {1'b0, wr_word[14:0]} : wr_word;

    always_comb begin
        case (rd_addr)
            REG_BMSR: rd_word = BMSR_FIXED | {10'b0, an_done, 2'b00, link_up, 2'b00};
            REG_ID1:  rd_word = PHYID1;
            REG_ID2:  rd_word = PHYID2;
            default:  rd_word = regs_q[rd_addr];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        regad_d    = regad_q;
        rd_d       = rd_q;
        sr_d       = sr_q;
        mdio_o_d   = mdio_o_q;
        mdio_t_d   = mdio_t_q;
        wr_valid_d = 1'b0;
        wr_regad_d = wr_regad_q;
        wr_data_d  = wr_data_q;
        wr_en      = 1'b0;
        if (mdc_rise) begin
            case (state_q)
                ST_PRE: begin
                    if (mdio_s) begin
                        if (pre_cnt_q < PRE_MIN_C) pre_cnt_d = pre_cnt_q + 1'b1;
                    end else if (pre_cnt_q >= PRE_MIN_C) begin
                        state_d = ST_ST1;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                ST_ST1: begin
                    pre_cnt_d = '0;
                    if (mdio_s) begin
                        state_d = ST_HDR;
                        cnt_d   = 5'd11;
                    end else begin
                        state_d = ST_PRE;
                    end
                end
                ST_HDR: begin
                    hdr_d = {hdr_q[9:0], mdio_s};
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else if (hdr_ok) begin
                        state_d = ST_TA;
                        cnt_d   = 5'd1;
                        regad_d = rd_addr;
                        rd_d    = (hdr_q[10:9] == OP_READ);
                        if (hdr_q[10:9] == OP_READ) sr_d = rd_word;
                    end else begin
                        state_d = ST_SKIP;
                        cnt_d   = 5'd17;
                    end
                end
                ST_TA: begin
                    if (cnt_q != 5'd0) begin
                        cnt_d = 5'd0;
                        if (rd_q) begin
                            mdio_t_d = 1'b0;
                            mdio_o_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = 5'd15;
                        sr_d    = wr_word;
                        if (rd_q) mdio_o_d = sr_q[15];
                    end
                end
                ST_DATA: begin
                    sr_d = wr_word;
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                        if (rd_q) mdio_o_d = sr_q[15];
                    end else begin
                        state_d  = ST_PRE;
                        mdio_t_d = 1'b1;
                        mdio_o_d = 1'b1;
                        if (!rd_q) begin
                            wr_en      = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_regad_d = regad_q;
                            wr_data_d  = wr_word;
                        end
                    end
                end
                ST_SKIP: begin
                    if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
                    else               state_d = ST_PRE;
                end
                default: state_d = ST_PRE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PRE;
            pre_cnt_q  <= '0;
            cnt_q      <= '0;
            hdr_q      <= '0;
            regad_q    <= '0;
            rd_q       <= 1'b0;
            sr_q       <= '0;
            mdio_o_q   <= 1'b1;
            mdio_t_q   <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_regad_q <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            regad_q    <= regad_d;
            rd_q       <= rd_d;
            sr_q       <= sr_d;
            mdio_o_q   <= mdio_o_d;
            mdio_t_q   <= mdio_t_d;
            wr_valid_q <= wr_valid_d;
            wr_regad_q <= wr_regad_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // A BMCR reset write discards its data and restores every RW register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= reg_rst_val(5'(i));
        end else if (wr_en) begin
            if ((regad_q == REG_BMCR) && wr_word[15]) begin
                for (int i = 0; i < 32; i++) regs_q[i] <= reg_rst_val(5'(i));
            end else if (!reg_is_ro(regad_q)) begin
                regs_q[regad_q] <= wr_store;
            end
        end
    end

    assign mdio_o   = mdio_o_q;
    assign mdio_t   = mdio_t_q;
    assign wr_valid = wr_valid_q;
    assign wr_regad = wr_regad_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_eth_mdio_responder.sv
// Randomized bench for eth_mdio_responder: drives MDC/MDIO frames and compares against a register-map model.
module tb_eth_mdio_responder;

    localparam logic [4:0] PHY = 5'd1;
    localparam int         PMIN = 32;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        m_drv = 1'b1;
    logic        mdio_i, mdio_o, mdio_t;
    logic        link_up = 1'b0, an_done = 1'b0;
    logic        wr_valid;
    logic [4:0]  wr_regad;
    logic [15:0] wr_data;

    int n_checks = 0;
    int n_fail = 0;
    int wr_hi_cnt = 0;
    logic saw_drive = 1'b0;

    logic [15:0] mreg [32];
    logic [4:0]  exp_regad = 5'd0;
    logic [15:0] exp_wdata = 16'h0000;

    always #10 clk = ~clk;

    // Open-drain style bus: the PHY wins while it drives.
    assign mdio_i = mdio_t ? m_drv : mdio_o;

    eth_mdio_responder dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t),
        .link_up(link_up), .an_done(an_done), .wr_valid(wr_valid), .wr_regad(wr_regad), .wr_data(wr_data)
    );

    always @(negedge clk) begin
        if (wr_valid === 1'b1) wr_hi_cnt++;
        if (mdio_t === 1'b0) saw_drive = 1'b1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 16'h0000;
        mreg[0] = 16'h3100;
        mreg[4] = 16'h01E1;
    endfunction

    function automatic logic [15:0] model_read(input logic [4:0] ra);
        case (ra)
            5'd1:    return 16'h7809 | (an_done ? 16'h0020 : 16'h0000) | (link_up ? 16'h0004 : 16'h0000);
            5'd2:    return 16'h0007;
            5'd3:    return 16'hC0F1;
            default: return mreg[ra];
        endcase
    endfunction

    function automatic void model_write(input logic [4:0] ra, input logic [15:0] wd);
        exp_regad = ra;
        exp_wdata = wd;
        if (ra == 5'd0 && wd[15]) model_reset();
        else if (ra == 5'd0) mreg[0] = wd & 16'h7FFF;
        else if (ra > 5'd3) mreg[ra] = wd;
    endfunction

    // One MDC period: master bit set up during low phase, PHY response sampled late in the high phase.
    task automatic mdc_bit(input logic b, output logic o_s, output logic t_s);
        m_drv = b;
        mdc = 1'b0;
        repeat ($urandom_range(4, 5)) @(negedge clk);
        mdc = 1'b1;
        repeat ($urandom_range(5, 6)) @(negedge clk);
        o_s = mdio_o;
        t_s = mdio_t;
    endtask

    task automatic run_frame(input string name, input int npre, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd);
        logic [31:0] fr;
        logic [15:0] rd, exp_rd;
        logic o, t, ta_t, ta_o, end_t, served, is_rd, b;
        int hi0;
        served = (npre >= PMIN) && (op == OP_RD || op == OP_WR) && (phy == PHY);
        is_rd  = (op == OP_RD);
        exp_rd = model_read(ra);
        hi0 = wr_hi_cnt;
        saw_drive = 1'b0;
        fr = {2'b01, op, phy, ra, 2'b10, wd};
        rd = 16'h0; ta_t = 1'b1; ta_o = 1'b1; end_t = 1'b0;
        for (int i = 0; i < npre; i++) mdc_bit(1'b1, o, t);
        for (int n = 0; n < 32; n++) begin
            b = fr[31-n];
            if (is_rd && n >= 14) b = 1'b1;
            mdc_bit(b, o, t);
            if (n == 14) begin ta_t = t; ta_o = o; end
            if (n >= 15 && n <= 30) rd[30-n] = o;
            if (n == 31) end_t = t;
            if (is_rd && n == 20) begin
                link_up = 1'($urandom);
                an_done = 1'($urandom);
            end
        end
        if (served && is_rd) begin
            check_eq({name, ".ta_t"}, 32'(ta_t), 32'd0);
            check_eq({name, ".ta_o"}, 32'(ta_o), 32'd0);
            check_eq({name, ".rdata"}, 32'(rd), 32'(exp_rd));
            check_eq({name, ".end_t"}, 32'(end_t), 32'd1);
            check_eq({name, ".no_wr"}, 32'(wr_hi_cnt - hi0), 32'd0);
        end else begin
            if (served) model_write(ra, wd);
            check_eq({name, ".no_drive"}, 32'(saw_drive), 32'd0);
            check_eq({name, ".wr_pulses"}, 32'(wr_hi_cnt - hi0), served ? 32'd1 : 32'd0);
            check_eq({name, ".wr_regad"}, 32'(wr_regad), 32'(exp_regad));
            check_eq({name, ".wr_data"}, 32'(wr_data), 32'(exp_wdata));
        end
    endtask

    initial begin
        logic o, t;
        logic [1:0] op;
        logic [4:0] phy, ra;
        logic [15:0] wd;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst.mdio_o", 32'(mdio_o), 32'd1);
        check_eq("rst.mdio_t", 32'(mdio_t), 32'd1);
        check_eq("rst.wr_valid", 32'(wr_valid), 32'd0);
        check_eq("rst.wr_regad", 32'(wr_regad), 32'd0);
        check_eq("rst.wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_frame("id1", 32, OP_RD, PHY, 5'd2, 16'h0);
        run_frame("wr9", 32, OP_WR, PHY, 5'd9, 16'hA5A5);
        run_frame("rd9", 33, OP_RD, PHY, 5'd9, 16'h0);
        run_frame("short_pre", 31, OP_RD, PHY, 5'd2, 16'h0);
        run_frame("phy3", 32, OP_WR, 5'd3, 5'd4, 16'hBEEF);
        run_frame("op00", 32, 2'b00, PHY, 5'd4, 16'hBEEF);
        run_frame("rd4", 32, OP_RD, PHY, 5'd4, 16'h0);
        run_frame("wr4", 32, OP_WR, PHY, 5'd4, 16'h1234);
        run_frame("bmcr_rst", 32, OP_WR, PHY, 5'd0, 16'h8000);
        run_frame("rd4_back", 32, OP_RD, PHY, 5'd4, 16'h0);
        run_frame("rd0_back", 32, OP_RD, PHY, 5'd0, 16'h0);
        link_up = 1'b1;
        an_done = 1'b1;
        run_frame("bmsr", 32, OP_RD, PHY, 5'd1, 16'h0);

        // Reset in the middle of a read's data phase.
        run_frame("wr9b", 32, OP_WR, PHY, 5'd9, 16'h5A5A);
        for (int i = 0; i < 32; i++) mdc_bit(1'b1, o, t);
        for (int n = 0; n <= 20; n++) begin
            logic [31:0] fr;
            fr = {2'b01, OP_RD, PHY, 5'd9, 2'b11, 16'hFFFF};
            mdc_bit(fr[31-n], o, t);
        end
        check_eq("abort.pre_t", 32'(t), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("abort.async_t", 32'(mdio_t), 32'd1);
        repeat (3) @(negedge clk);
        model_reset();
        exp_regad = 5'd0;
        exp_wdata = 16'h0;
        mdc = 1'b0;
        m_drv = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort.wr_regad", 32'(wr_regad), 32'd0);
        run_frame("post_rst", 32, OP_RD, PHY, 5'd9, 16'h0);

        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 9));
            op = (r < 4) ? OP_RD : (r < 8) ? OP_WR : (r == 8) ? 2'b00 : 2'b11;
            phy = ($urandom_range(0, 4) == 0) ? 5'($urandom) : PHY;
            ra = 5'($urandom);
            wd = 16'($urandom);
            if (ra == 5'd0 && $urandom_range(0, 3) != 0) wd[15] = 1'b0;
            run_frame($sformatf("rnd%0d", k), int'($urandom_range(32, 34)), op, phy, ra, wd);
            if (op == OP_WR && $urandom_range(0, 1) == 1)
                run_frame($sformatf("rnd%0d_rb", k), 32, OP_RD, PHY, ra, 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
